isa_io_sequencer: RTL and testbench
===================================

ISA_IO_SEQUENCER -- requirements
Module: isa_io_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: address/AEN setup cycles before strobe.
REQ-002 SHALL have parameter STROBE_CYC, default 8: minimum IOR#/IOW# active cycles.
REQ-003 SHALL have parameter HOLD_CYC, default 1: address/data hold cycles after strobe release.
REQ-004 SHALL have parameter RECOVERY_CYC, default 4: idle cycles between bus cycles.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 256: WAIT-state limit.
REQ-006 SHALL have ports: clk in 1 (sole clock); reset_n in 1 (asynchronous, active-low).
REQ-007 SHALL have ports: req_valid in 2; req_ready out 2; req_write in 2 (per requester n = bit n).
REQ-008 SHALL have ports: req_addr in 20 (10 bits per requester, n at [10n+9:10n]); req_wdata in 16 (8 per requester).
REQ-009 SHALL have ports: rsp_valid out 1; rsp_id out 1; rsp_rdata out 8; rsp_err out 1.
REQ-010 SHALL have ports: isa_sa out 10; isa_aen out 1; isa_ior_n out 1; isa_iow_n out 1.
REQ-011 SHALL have ports: isa_d_out out 8; isa_d_oe out 1; isa_d_in in 8; isa_iochrdy in 1 (asynchronous).

Function
REQ-012 SHALL use states IDLE, SETUP, STROBE, WAIT, HOLD, RECOVER; all counters reload on state entry.
REQ-013 SHALL arbitrate round-robin: when both valid in IDLE, grant the requester not granted last; pointer resets to favour requester 0.
REQ-014 SHALL assert req_ready[n] combinationally only in IDLE for the granted valid requester; at most one bit high; transfer = valid & ready.
REQ-015 SHALL latch id, write, addr, wdata on accept cycle T and enter SETUP at T+1.
REQ-016 SHALL drive isa_aen=0 and isa_sa=latched addr from SETUP through HOLD; isa_aen=1 and isa_sa=0 otherwise.
REQ-017 SHALL, for writes, drive isa_d_oe=1 and isa_d_out=wdata from SETUP through HOLD; isa_d_oe=0 for reads.
REQ-018 SHALL hold isa_ior_n (read) or isa_iow_n (write) low for exactly STROBE_CYC cycles in STROBE plus all WAIT cycles.
REQ-019 SHALL pass isa_iochrdy through a 2-flop synchronizer; on the last STROBE cycle, synced value 0 enters WAIT, else HOLD.
REQ-020 SHALL leave WAIT for HOLD on the first cycle synced iochrdy=1.
REQ-021 SHALL capture isa_d_in into rsp_rdata on the final strobe-active cycle of a read; rsp_rdata=0 for writes.
REQ-022 SHALL pulse rsp_valid one cycle on the first RECOVER cycle with rsp_id=latched id; no waits: rsp_valid at T+1+SETUP_CYC+STROBE_CYC+HOLD_CYC (T+12 default).
REQ-023 SHALL return to IDLE after RECOVERY_CYC cycles; next accept earliest on the IDLE cycle.
REQ-024 SHALL ignore req_valid changes outside IDLE; dropped valid before accept is not an error.

Reset
REQ-025 SHALL, while reset_n=0, force IDLE, isa_ior_n=1, isa_iow_n=1, isa_aen=1, isa_sa=0, isa_d_oe=0, isa_d_out=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, synchronizer=0, RR pointer=0.
REQ-026 SHALL, on reset mid-cycle, release strobes and data bus immediately and emit no response for the aborted cycle.

Configuration
REQ-027 SHALL, with ISA_SEQ_TIMEOUT_EN defined, after TIMEOUT_CYC WAIT cycles release the strobe, enter HOLD, set rsp_err=1 and rsp_rdata=8'hFF.
REQ-028 SHALL, without ISA_SEQ_TIMEOUT_EN, wait indefinitely in WAIT, tie rsp_err=0, and contain no timeout counter.

Structure
REQ-029 SHALL place the state enum and default timing constants in package isa_seq_pkg.
REQ-030 SHALL implement arbitration in sub-module isa_rr_arbiter (2 requesters, grant vector, pointer update on accept).

Verification
REQ-031 Req0 write addr 0x22C data 0xD1, iochrdy=1 -> iow_n low 8 cycles, isa_d_out=0xD1 with oe=1, rsp_valid at T+12, rsp_err=0.
REQ-032 Req1 read addr 0x22A, isa_d_in=0xAA, iochrdy=1 -> ior_n low 8 cycles, rsp_rdata=0xAA, rsp_id=1.
REQ-033 Both valid every cycle, 4 transfers -> grants 0,1,0,1; no accept outside IDLE.
REQ-034 Read with iochrdy low 20 cycles -> ior_n extended, data captured at final strobe cycle, rsp_err=0.
REQ-035 Iochrdy stuck low, macro defined -> strobe released after 256 WAIT cycles, rsp_err=1, rsp_rdata=0xFF; undefined -> no response.
REQ-036 reset_n low during STROBE of a write -> iow_n=1, isa_d_oe=0 same cycle, no rsp_valid, next request proceeds normally.

Source files
------------

// File: rtl/isa_seq_pkg.sv
// Shared types and default timing for the ISA I/O sequencer.
// Optional feature macro: ISA_SEQ_TIMEOUT_EN (bounded IOCHRDY wait).
package isa_seq_pkg;

  // Bus-cycle phases, in the order a transfer walks through them.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5
  } seq_state_t;

  // Default bus timing, in clk cycles.
  localparam int DEF_SETUP_CYC    = 2;
  localparam int DEF_STROBE_CYC   = 8;
  localparam int DEF_HOLD_CYC     = 1;
  localparam int DEF_RECOVERY_CYC = 4;
  localparam int DEF_TIMEOUT_CYC  = 256;

  // Geometry of the request side and the ISA bus.
  localparam int N_REQ  = 2;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  // One phase counter serves every state; wide enough for any sane timing.
  localparam int CNT_W = 16;

  // Reload value for a phase lasting 'cycles' clocks (counts down to zero).
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    if (cycles < 1) begin
      return '0;
    end
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/isa_rr_arbiter.sv
// Two-requester round-robin arbiter. The grant vector is purely
// combinational; the priority pointer only moves when a grant is accepted.
module isa_rr_arbiter
  import isa_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             accept,
  output logic [N_REQ-1:0] grant
);

  // ptr = index of the requester favoured on a tie (0 after reset).
  logic ptr_q;

  // Pick a single requester; ties go to the one not granted last.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // After an accepted grant, favour the other requester next time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/isa_io_sequencer.sv
// ISA I/O bus-cycle sequencer: arbitrates two requesters and runs one
// IOR#/IOW# cycle at a time with programmable setup/strobe/hold/recovery,
// stretching the strobe while the synchronized IOCHRDY is low.
// Optional feature macro: ISA_SEQ_TIMEOUT_EN -- when defined, a WAIT phase
// longer than TIMEOUT_CYC is abandoned and reported with rsp_err=1.
//
// Handshake: a request transfers on a cycle where req_valid[n] and
// req_ready[n] are both high. req_ready is combinational, only asserted in
// IDLE, and has at most one bit set. rsp_valid is a single-cycle pulse with
// no back-pressure; rsp_id/rsp_rdata/rsp_err are valid while it is high.
module isa_io_sequencer
  import isa_seq_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int RECOVERY_CYC = DEF_RECOVERY_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_id,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       isa_sa,
  output logic                    isa_aen,
  output logic                    isa_ior_n,
  output logic                    isa_iow_n,
  output logic [DATA_W-1:0]       isa_d_out,
  output logic                    isa_d_oe,
  input  logic [DATA_W-1:0]       isa_d_in,
  input  logic                    isa_iochrdy,
  output seq_state_t              dbg_state
);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_s1_q, rdy_s2_q;
  logic              id_q, write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              rsp_valid_q;
  logic [N_REQ-1:0]  grant;
  logic              accept;
  logic              acc_id;
  logic              capture;
  logic              bus_active;
  logic              strobe_on;
`ifdef ISA_SEQ_TIMEOUT_EN
  logic              timeout_hit;
  logic              err_q;
`endif

  isa_rr_arbiter u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .accept    (accept),
    .grant     (grant)
  );

  // Ready only while idle and out of reset, so nothing is accepted mid-cycle.
  assign req_ready = (state_q == ST_IDLE && reset_n) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign acc_id    = grant[1];

  // IOCHRDY is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_s1_q <= 1'b0;
      rdy_s2_q <= 1'b0;
    end else begin
      rdy_s1_q <= isa_iochrdy;
      rdy_s2_q <= rdy_s1_q;
    end
  end

  // State and phase-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; every transition reloads the counter for the new phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
`ifdef ISA_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SETUP;
          cnt_d   = cnt_load(SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = cnt_load(STROBE_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (rdy_s2_q) begin
            // Last strobe cycle with the device ready: sample read data now.
            capture = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = cnt_load(HOLD_CYC);
          end else begin
            state_d = ST_WAIT;
`ifdef ISA_SEQ_TIMEOUT_EN
            cnt_d   = cnt_load(TIMEOUT_CYC);
`else
            cnt_d   = '0;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (rdy_s2_q) begin
          capture = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = cnt_load(HOLD_CYC);
        end
`ifdef ISA_SEQ_TIMEOUT_EN
        else if (cnt_q == '0) begin
          timeout_hit = 1'b1;
          state_d     = ST_HOLD;
          cnt_d       = cnt_load(HOLD_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = cnt_load(RECOVERY_CYC);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request latch on accept, read-data capture, and the response pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_q        <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ISA_SEQ_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= (state_q == ST_HOLD) && (state_d == ST_RECOVER);
      if (accept) begin
        id_q    <= acc_id;
        write_q <= req_write[acc_id];
        addr_q  <= acc_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        wdata_q <= acc_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
        rdata_q <= '0;
`ifdef ISA_SEQ_TIMEOUT_EN
        err_q   <= 1'b0;
`endif
      end
      if (capture && !write_q) begin
        rdata_q <= isa_d_in;
      end
`ifdef ISA_SEQ_TIMEOUT_EN
      if (timeout_hit) begin
        rdata_q <= 8'hFF;
        err_q   <= 1'b1;
      end
`endif
    end
  end

  // Bus drive decoded from the registered state so reset releases it at once.
  assign bus_active = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                      (state_q == ST_WAIT)  || (state_q == ST_HOLD);
  assign strobe_on  = (state_q == ST_STROBE) || (state_q == ST_WAIT);

  assign isa_aen   = ~bus_active;
  assign isa_sa    = bus_active ? addr_q : '0;
  assign isa_d_oe  = bus_active & write_q;
  assign isa_d_out = isa_d_oe ? wdata_q : '0;
  assign isa_ior_n = ~(strobe_on & ~write_q);
  assign isa_iow_n = ~(strobe_on & write_q);

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_rdata = rdata_q;
`ifdef ISA_SEQ_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  assign dbg_state = state_q;

endmodule

// File: tb/tb_isa_io_sequencer.sv
// Directed bench for isa_io_sequencer with a response scoreboard.
// Honours ISA_SEQ_TIMEOUT_EN for the stuck-IOCHRDY scenario.
`timescale 1ns/1ps
module tb_isa_io_sequencer;
  import isa_seq_pkg::*;

  localparam int T_SETUP  = 2;
  localparam int T_STROBE = 8;
  localparam int T_HOLD   = 1;
  localparam int T_RECOV  = 4;
  localparam int T_TMO    = 256;
  localparam int LAT      = 1 + T_SETUP + T_STROBE + T_HOLD;  // 12
  localparam int RDY_RAISE = 20;  // iochrdy raised at start of cycle T+20

  // ---------------- DUT signals ----------------
  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_write;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [9:0]  isa_sa;
  logic        isa_aen, isa_ior_n, isa_iow_n, isa_d_oe, isa_iochrdy;
  logic [7:0]  isa_d_out, isa_d_in;
  seq_state_t  dbg_state;

  isa_io_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .isa_sa      (isa_sa),
    .isa_aen     (isa_aen),
    .isa_ior_n   (isa_ior_n),
    .isa_iow_n   (isa_iow_n),
    .isa_d_out   (isa_d_out),
    .isa_d_oe    (isa_d_oe),
    .isa_d_in    (isa_d_in),
    .isa_iochrdy (isa_iochrdy),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic       id;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         acc_cyc;
    int         lat;
    int         slen;
  } exp_t;

  exp_t       exp_q[$];
  int         grant_log[$];
  exp_t       e_cur;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc_count = 0;
  int         acc_last = 0;
  int         earliest = 0;
  int         slen_obs = 0;
  int         mode = 0;        // 0 ready, 1 delayed ready, 2 stuck low
  logic       ptr_m = 1'b0;
  logic       din_ramp = 1'b0;
  logic [7:0] din_const = 8'h00;
  logic [1:0] g_m, ready_m;
  logic       strobe_low;

  function automatic logic [7:0] ramp(input int c);
    int v;
    v = c * 37 + 5;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- clock / cycle counter / data-bus driver ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    isa_d_in = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      isa_d_in = din_ramp ? ramp(cyc) : din_const;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (samples on negedge) ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      ptr_m    = 1'b0;
      earliest = 0;
      slen_obs = 0;
    end else begin
      // responses
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("rsp_valid_unexpected", rsp_valid, 1'b0);
        end else begin
          e_cur = exp_q.pop_front();
          check("rsp_id", rsp_id, e_cur.id);
          check("rsp_rdata", rsp_rdata, e_cur.rdata);
          check("rsp_err", rsp_err, e_cur.err);
          check("rsp_latency", cyc - e_cur.acc_cyc, e_cur.lat);
          earliest = cyc + T_RECOV;
        end
      end
      // strobe phase and bus contents
      strobe_low = (isa_ior_n === 1'b0) || (isa_iow_n === 1'b0);
      if (exp_q.size() != 0 && strobe_low) begin
        e_cur = exp_q[0];
        slen_obs++;
        check("strobe_sel", {isa_ior_n, isa_iow_n}, e_cur.wr ? 2'b10 : 2'b01);
        check("aen_strobe", isa_aen, 1'b0);
        check("sa_strobe", isa_sa, e_cur.addr);
        check("d_oe_strobe", isa_d_oe, e_cur.wr);
        if (e_cur.wr) check("d_out_strobe", isa_d_out, e_cur.wdata);
      end else begin
        if (slen_obs != 0 && exp_q.size() != 0) begin
          check("strobe_len", slen_obs, exp_q[0].slen);
        end
        slen_obs = 0;
        if (exp_q.size() == 0) begin
          check("idle_aen", isa_aen, 1'b1);
          check("idle_sa", isa_sa, 10'h000);
          check("idle_strobes", {isa_ior_n, isa_iow_n}, 2'b11);
          check("idle_d_oe", isa_d_oe, 1'b0);
        end
      end
      // arbitration model and accept
      case (req_valid)
        2'b01:   g_m = 2'b01;
        2'b10:   g_m = 2'b10;
        2'b11:   g_m = ptr_m ? 2'b10 : 2'b01;
        default: g_m = 2'b00;
      endcase
      ready_m = (exp_q.size() == 0 && cyc >= earliest) ? g_m : 2'b00;
      check("req_ready", req_ready, ready_m);
      if (ready_m != 2'b00) begin
        e_cur.id      = ready_m[1];
        e_cur.wr      = req_write[ready_m[1]];
        e_cur.addr    = ready_m[1] ? req_addr[19:10] : req_addr[9:0];
        e_cur.wdata   = ready_m[1] ? req_wdata[15:8] : req_wdata[7:0];
        e_cur.acc_cyc = cyc;
        e_cur.err     = 1'b0;
        if (mode == 1) begin
          e_cur.lat   = LAT + (RDY_RAISE + 2 - (T_SETUP + T_STROBE));
          e_cur.slen  = RDY_RAISE;
          e_cur.rdata = e_cur.wr ? 8'h00 : ramp(cyc + RDY_RAISE + 2);
        end else if (mode == 2) begin
          e_cur.lat   = LAT + T_TMO;
          e_cur.slen  = T_STROBE + T_TMO;
          e_cur.rdata = 8'hFF;
          e_cur.err   = 1'b1;
        end else begin
          e_cur.lat   = LAT;
          e_cur.slen  = T_STROBE;
          e_cur.rdata = e_cur.wr ? 8'h00 : din_const;
        end
        exp_q.push_back(e_cur);
        grant_log.push_back(int'(req_ready[1]));
        ptr_m    = ready_m[0];
        acc_last = cyc;
        acc_count++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input int target, input int budget);
    int n;
    n = 0;
    while (acc_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_seen", (acc_count >= target), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_seen", exp_q.size(), 0);
    repeat (T_RECOV + 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n     = 1'b0;
    req_valid   = 2'b00;
    req_write   = 2'b00;
    req_addr    = '0;
    req_wdata   = '0;
    isa_iochrdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset values, with requests pending to show ready stays low
    req_valid = 2'b11;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_ior_n", isa_ior_n, 1'b1);
    check("rst_iow_n", isa_iow_n, 1'b1);
    check("rst_aen", isa_aen, 1'b1);
    check("rst_sa", isa_sa, 10'h000);
    check("rst_d_oe", isa_d_oe, 1'b0);
    check("rst_d_out", isa_d_out, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 8'h00);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    req_valid = 2'b00;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // requester 0 write 0x22C <- 0xD1
    mode = 0;
    req_write = 2'b01; req_addr[9:0] = 10'h22C; req_wdata[7:0] = 8'hD1;
    req_valid = 2'b01;
    wait_acc(acc_count + 1, 50);
    req_valid = 2'b00;
    wait_idle(100);

    // requester 1 read 0x22A, device returns 0xAA
    din_const = 8'hAA;
    req_write = 2'b00; req_addr[19:10] = 10'h22A;
    req_valid = 2'b10;
    wait_acc(acc_count + 1, 50);
    req_valid = 2'b00;
    wait_idle(100);

    // both requesters held valid: four transfers alternate 0,1,0,1
    begin
      int base;
      base = grant_log.size();
      din_const = 8'h3C;
      req_write = 2'b01;
      req_addr  = {10'h301, 10'h300};
      req_wdata = {8'h00, 8'h5A};
      req_valid = 2'b11;
      wait_acc(acc_count + 4, 200);
      req_valid = 2'b00;
      wait_idle(100);
      for (int i = 0; i < 4; i++) begin
        check("grant_order", grant_log[base + i], i % 2);
      end
    end

    // read stretched by IOCHRDY low; data ramps every cycle
    mode = 1; din_ramp = 1'b1; isa_iochrdy = 1'b0;
    req_write = 2'b00; req_addr[19:10] = 10'h2F0;
    req_valid = 2'b10;
    wait_acc(acc_count + 1, 50);
    req_valid = 2'b00;
    wait_cyc(acc_last + RDY_RAISE);
    isa_iochrdy = 1'b1;
    wait_idle(100);
    din_ramp = 1'b0;

    // IOCHRDY stuck low
    mode = 2; isa_iochrdy = 1'b0;
    req_write = 2'b00; req_addr[9:0] = 10'h1F0;
    req_valid = 2'b01;
    wait_acc(acc_count + 1, 50);
    req_valid = 2'b00;
`ifdef ISA_SEQ_TIMEOUT_EN
    wait_idle(400);
    isa_iochrdy = 1'b1;
`else
    repeat (300) begin
      @(posedge clk); #1;
    end
    check("stuck_ior_n", isa_ior_n, 1'b0);
    check("stuck_no_rsp", exp_q.size(), 1);
    reset_n = 1'b0;
    #1;
    check("stuck_rst_ior_n", isa_ior_n, 1'b1);
    exp_q.delete();
    isa_iochrdy = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
`endif

    // reset asserted while a write strobe is active
    mode = 0;
    req_write = 2'b01; req_addr[9:0] = 10'h2C4; req_wdata[7:0] = 8'h96;
    req_valid = 2'b01;
    wait_acc(acc_count + 1, 50);
    req_valid = 2'b00;
    wait_cyc(acc_last + 5);
    check("abort_pre_iow_n", isa_iow_n, 1'b0);
    reset_n = 1'b0;
    #1;
    check("abort_iow_n", isa_iow_n, 1'b1);
    check("abort_d_oe", isa_d_oe, 1'b0);
    check("abort_aen", isa_aen, 1'b1);
    check("abort_d_out", isa_d_out, 8'h00);
    exp_q.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
    end

    // next request after the abort runs normally
    req_write = 2'b10; req_addr[19:10] = 10'h2C6; req_wdata[15:8] = 8'h4B;
    req_valid = 2'b10;
    wait_acc(acc_count + 1, 50);
    req_valid = 2'b00;
    wait_idle(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
